// File: rtl/vx_mem_bus_arbiter.sv
// vx_mem_bus_arbiter
// Shares one downstream memory bus among NUM_REQS upstream requesters.
// Arbitration is round-robin. A grant that is stalled by out_req_ready stays
// locked to its requester until it is accepted. The requester index is
// appended to the downstream tag in its LSBs, and responses are routed back
// by that index. Each requester may have at most MAX_OUTSTANDING reads without
// a response.
//
// The upstream and downstream buses are flattened into per-requester packed
// arrays:
//   in_*  : upstream buses
//   out_* : downstream bus
//
// Optional build macro VX_MEM_ARB_LOADER_PRIO_EN:
//   - Requester 0 (the loader) wins whenever it is eligible and no lock is held.
//   - The other requesters round-robin among themselves, so rr_ptr never
//     holds 0 in this build.
module vx_mem_bus_arbiter #(
  parameter  int NUM_REQS        = 2,
  parameter  int DATA_WIDTH      = 512,
  parameter  int ADDR_WIDTH      = 26,
  parameter  int TAG_WIDTH       = 48,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int IDX_W           = (NUM_REQS > 2) ? $clog2(NUM_REQS) : 1,
  localparam int OUT_TAG_W       = TAG_WIDTH + IDX_W
) (
  input  logic                                 clk,
  input  logic                                 reset,
  // upstream request channels
  input  logic [NUM_REQS-1:0]                  in_req_valid,
  input  logic [NUM_REQS-1:0]                  in_req_rw,
  input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]  in_req_addr,
  input  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]  in_req_data,
  input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]   in_req_tag,
  output logic [NUM_REQS-1:0]                  in_req_ready,
  // upstream response channels
  output logic [NUM_REQS-1:0]                  in_rsp_valid,
  output logic [NUM_REQS-1:0][DATA_WIDTH-1:0]  in_rsp_data,
  output logic [NUM_REQS-1:0][TAG_WIDTH-1:0]   in_rsp_tag,
  input  logic [NUM_REQS-1:0]                  in_rsp_ready,
  // downstream request channel
  output logic                                 out_req_valid,
  output logic                                 out_req_rw,
  output logic [ADDR_WIDTH-1:0]                out_req_addr,
  output logic [DATA_WIDTH-1:0]                out_req_data,
  output logic [OUT_TAG_W-1:0]                 out_req_tag,
  input  logic                                 out_req_ready,
  // downstream response channel
  input  logic                                 out_rsp_valid,
  input  logic [DATA_WIDTH-1:0]                out_rsp_data,
  input  logic [OUT_TAG_W-1:0]                 out_rsp_tag,
  output logic                                 out_rsp_ready,
  output logic                                 busy
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

`ifdef VX_MEM_ARB_LOADER_PRIO_EN
  localparam idx_t RR_FIRST = idx_t'(1);
`else
  localparam idx_t RR_FIRST = idx_t'(0);
`endif

  idx_t                 rr_ptr;
  logic                 locked;
  idx_t                 lock_idx;
  cnt_t [NUM_REQS-1:0]  outst;

  logic [NUM_REQS-1:0]  eligible;
  logic                 rr_found;
  idx_t                 rr_idx;
  logic                 win_valid;
  idx_t                 win_idx;
  logic                 req_fire;
  idx_t                 rsp_idx;
  logic                 rsp_hit;
  logic                 rsp_fire;

  // A read may only be issued while its requester is below the outstanding cap.
  // Writes are never capped.
  for (genvar g = 0; g < NUM_REQS; g++) begin : g_elig
    assign eligible[g] = in_req_valid[g] & (in_req_rw[g] | (outst[g] < cnt_t'(MAX_OUTSTANDING)));
  end

  // Round-robin search: find the first eligible requester at or after rr_ptr.
  always_comb begin
    int cand;
    // NOTE: every variable written here gets a default first so that no path
    // leaves it unassigned and infers a latch.
    cand     = 0;
    rr_found = 1'b0;
    rr_idx   = '0;
`ifdef VX_MEM_ARB_LOADER_PRIO_EN
    for (int k = 0; k < NUM_REQS - 1; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQS) cand = cand - (NUM_REQS - 1);
      if (!rr_found && eligible[idx_t'(cand)]) begin
        rr_found = 1'b1;
        rr_idx   = idx_t'(cand);
      end
    end
`else
    for (int k = 0; k < NUM_REQS; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQS) cand = cand - NUM_REQS;
      if (!rr_found && eligible[idx_t'(cand)]) begin
        rr_found = 1'b1;
        rr_idx   = idx_t'(cand);
      end
    end
`endif
  end

  // Winner selection: a held lock overrides the search, so a stalled request
  // is never re-arbitrated away.
  always_comb begin
    win_valid = rr_found;
    win_idx   = rr_idx;
`ifdef VX_MEM_ARB_LOADER_PRIO_EN
    if (eligible[0]) begin
      win_valid = 1'b1;
      win_idx   = '0;
    end
`endif
    if (locked) begin
      win_valid = in_req_valid[lock_idx];
      win_idx   = lock_idx;
    end
  end

  // Forward the winner downstream. Its index is placed in the tag LSBs.
  // Only the winner sees out_req_ready.
  assign out_req_valid = reset & win_valid;
  assign out_req_rw    = in_req_rw[win_idx];
  assign out_req_addr  = in_req_addr[win_idx];
  assign out_req_data  = in_req_data[win_idx];
  assign out_req_tag   = {in_req_tag[win_idx], win_idx};
  assign req_fire      = out_req_valid & out_req_ready;

  // Return ready only to the current winner.
  always_comb begin
    in_req_ready = '0;
    if (reset && win_valid) in_req_ready[win_idx] = out_req_ready;
  end

  // Response routing. A response with an unknown index, or for a requester
  // with no outstanding read, is accepted and dropped. This covers stale
  // responses that arrive after a reset.
  assign rsp_idx = out_rsp_tag[IDX_W-1:0];

  // Route each response by its tag index, or accept and drop it.
  always_comb begin
    rsp_hit       = 1'b0;
    in_rsp_valid  = '0;
    out_rsp_ready = 1'b0;
    if (int'(rsp_idx) < NUM_REQS) rsp_hit = (outst[rsp_idx] != '0);
    if (reset) begin
      if (rsp_hit) begin
        in_rsp_valid[rsp_idx] = out_rsp_valid;
        out_rsp_ready         = in_rsp_ready[rsp_idx];
      end else begin
        out_rsp_ready = 1'b1;
      end
    end
  end

  assign rsp_fire = out_rsp_valid & out_rsp_ready & rsp_hit;

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_rsp
    assign in_rsp_data[g] = out_rsp_data;
    assign in_rsp_tag[g]  = out_rsp_tag[OUT_TAG_W-1:IDX_W];
  end

  // Per-requester read counters. An issue and a response in the same cycle
  // cancel out.
  for (genvar g = 0; g < NUM_REQS; g++) begin : g_cnt
    logic inc, dec;
    assign inc = req_fire & ~out_req_rw & (win_idx == idx_t'(g));
    assign dec = rsp_fire & (rsp_idx == idx_t'(g));

    // NOTE: the counters are reset like any other register, because they
    // gate eligibility and must be zero the moment reset releases.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        outst[g] <= '0;
      end else if (inc && !dec) begin
        outst[g] <= outst[g] + cnt_t'(1);
      end else if (dec && !inc) begin
        outst[g] <= outst[g] - cnt_t'(1);
      end
    end
  end

  // Arbitration state:
  //   - An accepted grant advances the pointer and clears the lock.
  //   - A stalled grant takes the lock.
  //   - A locked requester that withdraws its request only drops the lock.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= RR_FIRST;
      locked   <= 1'b0;
      lock_idx <= '0;
    end else if (req_fire) begin
      locked <= 1'b0;
`ifdef VX_MEM_ARB_LOADER_PRIO_EN
      if (win_idx != '0)
        rr_ptr <= (win_idx == idx_t'(NUM_REQS - 1)) ? RR_FIRST : win_idx + idx_t'(1);
`else
      rr_ptr <= (win_idx == idx_t'(NUM_REQS - 1)) ? RR_FIRST : win_idx + idx_t'(1);
`endif
    end else if (out_req_valid) begin
      locked   <= 1'b1;
      lock_idx <= win_idx;
    end else if (locked) begin
      locked <= 1'b0;
    end
  end

  assign busy = reset & (locked | (|outst));

endmodule

// File: tb/tb_vx_mem_bus_arbiter.sv
// Testbench for vx_mem_bus_arbiter: two requesters, cap of four reads.
// Stimulus pushes expected downstream grants and upstream responses into
// queues. A monitor on the falling edge pops and compares them on every
// handshake. Direct checks cover reset, lock, cap and routing boundaries.
module tb_vx_mem_bus_arbiter;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int AW = 26;
  localparam int TW = 48;
  localparam int MO = 4;
  localparam int IW = 1;

  typedef struct {
    int             port;
    logic           rw;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    logic [TW+IW-1:0] tag;
  } exp_req_t;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } exp_rsp_t;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NR-1:0]            in_req_valid, in_req_rw, in_req_ready;
  logic [NR-1:0][AW-1:0]    in_req_addr;
  logic [NR-1:0][DW-1:0]    in_req_data;
  logic [NR-1:0][TW-1:0]    in_req_tag;
  logic [NR-1:0]            in_rsp_valid, in_rsp_ready;
  logic [NR-1:0][DW-1:0]    in_rsp_data;
  logic [NR-1:0][TW-1:0]    in_rsp_tag;
  logic                     out_req_valid, out_req_rw, out_req_ready;
  logic [AW-1:0]            out_req_addr;
  logic [DW-1:0]            out_req_data;
  logic [TW+IW-1:0]         out_req_tag;
  logic                     out_rsp_valid, out_rsp_ready;
  logic [DW-1:0]            out_rsp_data;
  logic [TW+IW-1:0]         out_rsp_tag;
  logic                     busy;

  exp_req_t req_q[$];
  exp_rsp_t rsp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  vx_mem_bus_arbiter #(
    .NUM_REQS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_addr(in_req_addr),
    .in_req_data(in_req_data), .in_req_tag(in_req_tag), .in_req_ready(in_req_ready),
    .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
    .in_rsp_ready(in_rsp_ready),
    .out_req_valid(out_req_valid), .out_req_rw(out_req_rw), .out_req_addr(out_req_addr),
    .out_req_data(out_req_data), .out_req_tag(out_req_tag), .out_req_ready(out_req_ready),
    .out_rsp_valid(out_rsp_valid), .out_rsp_data(out_rsp_data), .out_rsp_tag(out_rsp_tag),
    .out_rsp_ready(out_rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic rw,
                       input logic [AW-1:0] addr, input logic [TW-1:0] tag);
    in_req_valid[p] = v;
    in_req_rw[p]    = rw;
    in_req_addr[p]  = addr;
    in_req_tag[p]   = tag;
    in_req_data[p]  = 32'h5A5A_0000 ^ tag[31:0];
  endtask

  task automatic push_req(input int p);
    exp_req_t e;
    e.port = p;
    e.rw   = in_req_rw[p];
    e.addr = in_req_addr[p];
    e.data = in_req_data[p];
    e.tag  = {in_req_tag[p], IW'(p)};
    req_q.push_back(e);
  endtask

  task automatic send_rsp(input int p, input logic [TW-1:0] tag, input logic [DW-1:0] data,
                          input logic expect_delivery);
    exp_rsp_t r;
    out_rsp_valid = 1'b1;
    out_rsp_tag   = {tag, IW'(p)};
    out_rsp_data  = data;
    if (expect_delivery) begin
      r.port = p;
      r.tag  = tag;
      r.data = data;
      rsp_q.push_back(r);
    end
  endtask

  // Scoreboard monitor, sampling away from the rising edge.
  exp_req_t mon_e;
  exp_rsp_t mon_r;
  always @(negedge clk) begin
    if (out_req_valid === 1'b1 && out_req_ready === 1'b1) begin
      if (req_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL req_unexpected: handshake with tag %0h, none expected", out_req_tag);
      end else begin
        mon_e = req_q.pop_front();
        check("req_grant", 64'(in_req_ready), 64'd1 << mon_e.port);
        check("req_rw",    64'(out_req_rw),   64'(mon_e.rw));
        check("req_addr",  64'(out_req_addr), 64'(mon_e.addr));
        check("req_data",  64'(out_req_data), 64'(mon_e.data));
        check("req_tag",   64'(out_req_tag),  64'(mon_e.tag));
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (in_rsp_valid[i] === 1'b1 && in_rsp_ready[i] === 1'b1) begin
        if (rsp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rsp_unexpected: port %0d tag %0h, none expected", i, in_rsp_tag[i]);
        end else begin
          mon_r = rsp_q.pop_front();
          check("rsp_port", 64'(i),              64'(mon_r.port));
          check("rsp_tag",  64'(in_rsp_tag[i]),  64'(mon_r.tag));
          check("rsp_data", 64'(in_rsp_data[i]), 64'(mon_r.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b0;
    in_req_valid  = '0;
    in_req_rw     = '0;
    in_req_addr   = '0;
    in_req_data   = '0;
    in_req_tag    = '0;
    in_rsp_ready  = '1;
    out_req_ready = 1'b1;
    out_rsp_valid = 1'b0;
    out_rsp_data  = '0;
    out_rsp_tag   = '0;

    // Reset with both requesters valid and a response pending: everything stays quiet.
    drive(0, 1'b1, 1'b0, 26'h10, 48'hA0);
    drive(1, 1'b1, 1'b0, 26'h20, 48'hB0);
    step();
    send_rsp(0, 48'h1, 32'h1, 1'b0);
    #2;
    check("rst_out_req_valid", 64'(out_req_valid), 64'd0);
    check("rst_in_req_ready",  64'(in_req_ready),  64'd0);
    check("rst_in_rsp_valid",  64'(in_rsp_valid),  64'd0);
    check("rst_out_rsp_ready", 64'(out_rsp_ready), 64'd0);
    check("rst_busy",          64'(busy),          64'd0);
    out_rsp_valid = 1'b0;
    step();

    // Round-robin burst of reads: grants alternate 0,1,0,1.
    // With the loader-priority build, port 0 wins every cycle.
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, 1'b0, 26'h10 + 26'(k), 48'hA0 + 48'(k));
      drive(1, 1'b1, 1'b0, 26'h20 + 26'(k), 48'hB0 + 48'(k));
`ifdef VX_MEM_ARB_LOADER_PRIO_EN
      push_req(0);
`else
      push_req(k % 2);
`endif
      step();
    end

    // Reset asserted mid-burst: outputs drop at once, without waiting for a clock.
    drive(0, 1'b1, 1'b0, 26'h14, 48'hA4);
    drive(1, 1'b1, 1'b0, 26'h24, 48'hB4);
    #1;
    check("burst_valid", 64'(out_req_valid), 64'd1);
    check("burst_busy",  64'(busy),          64'd1);
    reset = 1'b0;
    #1;
    check("midrst_out_req_valid", 64'(out_req_valid), 64'd0);
    check("midrst_in_req_ready",  64'(in_req_ready),  64'd0);
    check("midrst_busy",          64'(busy),          64'd0);
    step();

    // After reset is released, the first grant goes to port 0.
    reset = 1'b1;
    drive(0, 1'b1, 1'b0, 26'h18, 48'hA8);
    drive(1, 1'b1, 1'b0, 26'h28, 48'hB8);
    push_req(0);
    step();
    drive(0, 1'b0, 1'b0, 26'h0, 48'h0);
    drive(1, 1'b0, 1'b0, 26'h0, 48'h0);

    // A stale response for port 1 (no outstanding read) is accepted and dropped.
    send_rsp(1, 48'h7, 32'h7777_0000, 1'b0);
    #2;
    check("drop_rsp_ready", 64'(out_rsp_ready), 64'd1);
    check("drop_rsp_valid", 64'(in_rsp_valid),  64'd0);
    check("drop_busy",      64'(busy),          64'd1);
    step();

    // A single read from port 1.
    out_rsp_valid = 1'b0;
    drive(1, 1'b1, 1'b0, 26'h30, 48'hC1);
    push_req(1);
    step();
    drive(1, 1'b0, 1'b0, 26'h0, 48'h0);

    // A response tagged {5, 1} is routed to port 1 only.
    send_rsp(1, 48'h5, 32'hDEAD_0001, 1'b1);
    #2;
    check("route_rsp_valid", 64'(in_rsp_valid),  64'b10);
    check("route_rsp_ready", 64'(out_rsp_ready), 64'd1);
    step();

    // A port 0 response with upstream backpressure: out_rsp_ready follows port 0.
    in_rsp_ready[0] = 1'b0;
    send_rsp(0, 48'h9, 32'hBEEF_0000, 1'b0);
    #2;
    check("bp_rsp_ready", 64'(out_rsp_ready), 64'd0);
    check("bp_rsp_valid", 64'(in_rsp_valid),  64'b01);
    step();
    in_rsp_ready = '1;
    send_rsp(0, 48'h9, 32'hBEEF_0000, 1'b1);
    step();
    out_rsp_valid = 1'b0;
    #2;
    check("idle_busy", 64'(busy), 64'd0);
    step();

    // Lock: a port 1 write is stalled for 3 cycles.
    // Port 0 arriving later does not take the grant.
    out_req_ready = 1'b0;
    drive(1, 1'b1, 1'b1, 26'h4, 48'hD1);
    #2;
    check("lock0_valid", 64'(out_req_valid),  64'd1);
    check("lock0_idx",   64'(out_req_tag[0]), 64'd1);
    check("lock0_ready", 64'(in_req_ready),   64'd0);
    step();
    drive(0, 1'b1, 1'b1, 26'h8, 48'hE0);
    for (int k = 1; k < 3; k++) begin
      #2;
      check("lock_idx",  64'(out_req_tag[0]), 64'd1);
      check("lock_addr", 64'(out_req_addr),   64'h4);
      check("lock_busy", 64'(busy),           64'd1);
      step();
    end
    out_req_ready = 1'b1;
    push_req(1);
    #2;
    check("lock_release_ready", 64'(in_req_ready), 64'b10);
    step();
    drive(1, 1'b0, 1'b0, 26'h0, 48'h0);
    push_req(0);
    step();
    drive(0, 1'b0, 1'b0, 26'h0, 48'h0);
    #2;
    check("unlock_busy", 64'(busy), 64'd0);

    // Outstanding cap: four reads from port 0 are granted; the fifth is held.
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, 1'b0, 26'h100 + 26'(k), 48'hF0 + 48'(k));
      push_req(0);
      step();
    end
    drive(0, 1'b1, 1'b0, 26'h104, 48'hF4);
    #2;
    check("cap_valid", 64'(out_req_valid), 64'd0);
    check("cap_ready", 64'(in_req_ready),  64'd0);
    check("cap_busy",  64'(busy),          64'd1);
    step();

    // While port 0 is capped, a port 1 write still gets through.
    drive(1, 1'b1, 1'b1, 26'h200, 48'h11);
    push_req(1);
    #2;
    check("cap_write_ready", 64'(in_req_ready), 64'b10);
    step();
    drive(1, 1'b0, 1'b0, 26'h0, 48'h0);

    // One response frees a slot. The held read goes out on the next cycle.
    send_rsp(0, 48'hF0, 32'h0000_F0F0, 1'b1);
    #2;
    check("cap_still_held", 64'(out_req_valid), 64'd0);
    step();
    out_rsp_valid = 1'b0;
    push_req(0);
    #2;
    check("cap_regrant", 64'(out_req_valid), 64'd1);
    step();
    drive(0, 1'b0, 1'b0, 26'h0, 48'h0);

    // Drain the four remaining reads.
    for (int k = 1; k < 5; k++) begin
      send_rsp(0, 48'hF0 + 48'(k), 32'h0000_F0F0 + 32'(k), 1'b1);
      step();
    end
    out_rsp_valid = 1'b0;
    #2;
    check("drain_busy", 64'(busy), 64'd0);
    step();
    step();

    check("req_q_empty", 64'(req_q.size()), 64'd0);
    check("rsp_q_empty", 64'(rsp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vx_mem_bus_arbiter.md
# vx_mem_bus_arbiter

Shares one testbench memory-model bus among `NUM_REQS` masters, e.g. the memory loader on port 0 and the DUT memory port on port 1. Each cycle it selects one requester with a locked round-robin policy and forwards that request downstream. It appends the requester index to the tag, routes each response back by that index, and caps outstanding reads per requester.

## Interface
- `NUM_REQS`, 2: number of upstream requesters (2..8).
- `DATA_WIDTH`, 512: request/response data width.
- `ADDR_WIDTH`, 26: request address width.
- `TAG_WIDTH`, 48: upstream tag width; downstream tag is `TAG_WIDTH + IDX_W`, with `IDX_W = max(1, $clog2(NUM_REQS))`.
- `MAX_OUTSTANDING`, 4: maximum unanswered reads per requester.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: reset; asynchronous, active-low.
- `in_bus_if[NUM_REQS]`, VX_mem_bus_if.slave: upstream buses; req_valid/req_ready, req_data{rw,addr,data,tag}, rsp_valid/rsp_ready, rsp_data{data,tag}.
- `out_bus_if`, VX_mem_bus_if.master: downstream bus to the memory model, with the widened tag.
- `busy`, out, 1: high while any outstanding counter is non-zero or any request is held.

## Operation
- State:
  - `rr_ptr` (IDX_W bits): requester with the highest round-robin priority.
  - `locked` (1 bit) and `lock_idx` (IDX_W bits).
  - `outst[i]` per requester: 0..MAX_OUTSTANDING.
- Eligibility: requester i is eligible when `in[i].req_valid` is high AND (`rw`=1 OR `outst[i]` < MAX_OUTSTANDING). Writes never count as outstanding and never get a response.
- Grant when `locked`=0: first eligible requester scanning from `rr_ptr` upward with wrap.
- Grant when `locked`=1: `lock_idx`, regardless of the other requesters.
- Forwarding:
  - `out.req_valid` = winner valid.
  - `out.req_data` = winner's fields with tag = {winner tag, winner index}; the index occupies the tag LSBs.
  - `in[winner].req_ready` = `out.req_ready`; every other `in[j].req_ready` = 0.
- Lock: when `out.req_valid`=1 and `out.req_ready`=0, set `locked`=1 and `lock_idx`=winner. A non-accepted request is never re-arbitrated away.
- Handshake (`out.req_valid` & `out.req_ready`):
  - `locked` <= 0.
  - `rr_ptr` <= winner+1, wrapping to 0 at NUM_REQS.
  - If rw=0, `outst[winner]` increments.
- Response routing:
  - idx = `out.rsp_data.tag[IDX_W-1:0]`.
  - `in[idx].rsp_valid` = `out.rsp_valid`; `in[idx].rsp_data` = {data, tag stripped of the index}.
  - `out.rsp_ready` = `in[idx].rsp_ready`.
  - The other requesters see rsp_valid=0.
- A response handshake decrements `outst[idx]`.
  - A simultaneous read issue and response on the same requester leaves the counter unchanged.
  - A response for an index ≥ NUM_REQS or with `outst`=0 is accepted (rsp_ready=1) and dropped; the counter is unchanged.
- A requester that drops req_valid while locked is a protocol violation. In that case `locked` clears the next cycle and no state is otherwise altered.

## Timing
- Request path is combinational: zero-cycle latency from the upstream request to `out.req_valid`.
- Response path is combinational: zero cycles.
- Arbitration state updates one cycle after the handshake.
- Back-to-back grants every cycle are possible; with all requesters continuously valid and ready=1, each requester is granted once per NUM_REQS cycles.
- While `reset`=0:
  - `rr_ptr`=0, `locked`=0, `lock_idx`=0, all `outst`=0.
  - `out.req_valid`=0, all `in[i].req_ready`=0, all `in[i].rsp_valid`=0, `out.rsp_ready`=0, `busy`=0.
- Reset mid-transaction discards the lock and counters immediately (asynchronously); in-flight responses that arrive after reset release are dropped as above.
- No combinational path from `out.req_ready` to `out.req_valid`.

## Configuration
- `VX_MEM_ARB_LOADER_PRIO_EN` defined:
  - Requester 0 has strict priority over all others whenever it is eligible and no lock is held.
  - Remaining requesters round-robin among themselves; `rr_ptr` never points to 0.
- Undefined: pure round-robin across all requesters as described above.
- The lock rule applies in both builds.

## Test plan
- **Reset:** assert `reset`=0 mid-burst with req_valid high on both ports -> all outputs 0 within the same cycle, `busy`=0; after release, the first grant goes to port 0.
- **Round-robin:** both ports continuously issue reads, ready=1, MAX_OUTSTANDING large -> grants alternate 0,1,0,1; downstream tags end in index bits 0,1,0,1.
- **Lock:** port 1 write at addr 26'h4 with `out.req_ready`=0 for 3 cycles while port 0 is valid -> grant stays on port 1 until ready; port 0 is granted in the following cycle.
- **Response routing:** response with tag {48'h5, 1'b1} -> `in[1].rsp_valid`=1 with tag 48'h5; `in[0].rsp_valid`=0; `outst[1]` decrements.
- **Outstanding cap:** port 0 issues 4 reads with no responses, MAX_OUTSTANDING=4 -> 5th read is held; port 1 writes are still granted; one response to port 0 -> the 5th read is granted the next cycle.
- **Priority build:** with `VX_MEM_ARB_LOADER_PRIO_EN`, ports 0 and 1 both continuously valid -> port 0 wins every unlocked cycle; undefined build -> grants alternate.
